// File: rtl/conv33_window_gen.sv
// conv33_window_gen: streaming 3x3 sliding-window generator.
// Buffers the two previous image rows and emits one registered 3x3 window
// per unpadded output position, with valid/ready handshakes on both sides.
module conv33_window_gen #(
  parameter int DATA_W = 6,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DATA_W-1:0] win_0,
  output logic [DATA_W-1:0] win_1,
  output logic [DATA_W-1:0] win_2,
  output logic [DATA_W-1:0] win_3,
  output logic [DATA_W-1:0] win_4,
  output logic [DATA_W-1:0] win_5,
  output logic [DATA_W-1:0] win_6,
  output logic [DATA_W-1:0] win_7,
  output logic [DATA_W-1:0] win_8
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_lb_a [IMG_W];
  logic [DATA_W-1:0] r_lb_b [IMG_W];
  logic [DATA_W-1:0] r_sh   [9];
  logic [DATA_W-1:0] r_win  [9];
  logic              r_out_valid;
  logic              r_out_last;

  logic              w_accept;
  logic              w_xfer;
  logic              w_emit;
  logic              w_col_end;
  logic              w_row_end;
  logic [DATA_W-1:0] w_tap_top;
  logic [DATA_W-1:0] w_tap_mid;
  logic [DATA_W-1:0] w_sh_next [9];

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_out_valid && out_ready;
  assign w_col_end = (r_col == COL_LAST);
  assign w_row_end = (r_row == ROW_LAST);
  assign w_emit    = w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO);

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign win_0 = r_win[0];
  assign win_1 = r_win[1];
  assign win_2 = r_win[2];
  assign win_3 = r_win[3];
  assign win_4 = r_win[4];
  assign win_5 = r_win[5];
  assign win_6 = r_win[6];
  assign win_7 = r_win[7];
  assign win_8 = r_win[8];

  // Column taps and the shifted window (row-major, index = row*3 + col)
  always_comb begin
    w_tap_top    = r_lb_b[r_col];
    w_tap_mid    = r_lb_a[r_col];
    w_sh_next[0] = r_sh[1];
    w_sh_next[1] = r_sh[2];
    w_sh_next[2] = w_tap_top;
    w_sh_next[3] = r_sh[4];
    w_sh_next[4] = r_sh[5];
    w_sh_next[5] = w_tap_mid;
    w_sh_next[6] = r_sh[7];
    w_sh_next[7] = r_sh[8];
    w_sh_next[8] = in_pixel;
  end

  // Raster position counters, advancing once per accepted pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffers: lb_a holds row r-1, lb_b holds row r-2; never reset
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_lb_b[r_col] <= r_lb_a[r_col];
      r_lb_a[r_col] <= in_pixel;
    end
  end

  // Shift register follows every accept; output window loads on emit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh  <= '{default: '0};
      r_win <= '{default: '0};
    end else if (w_accept) begin
      r_sh <= w_sh_next;
      if (w_emit) begin
        r_win <= w_sh_next;
      end
    end
  end

  // Output valid/last: a new load wins over a transfer in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_row_end && w_col_end;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv33_window_gen.sv
// Testbench for conv33_window_gen with a 4x4 image of 6-bit pixels.
module tb_conv33_window_gen;

  localparam int DW = 6;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pixel;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [DW-1:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;

  conv33_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .win_0(win_0), .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4),
    .win_5(win_5), .win_6(win_6), .win_7(win_7), .win_8(win_8)
  );

  int total = 0;
  int bad   = 0;
  int got_cnt;

  typedef struct {
    logic [53:0] w;
    logic        last;
  } win_t;

  typedef struct packed {
    logic          iv;
    logic          ordy;
    logic [DW-1:0] px;
    logic          ov;
    logic          lst;
    logic [DW-1:0] w0;
    logic [DW-1:0] w8;
  } vec_t;

  logic [DW-1:0] px_q[$];
  win_t          exp_q[$];
  logic [DW-1:0] fr [W*H];
  vec_t          vt [17];

  function automatic logic [53:0] dut_win();
    return {win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: queue the frame's pixels and every window it must produce
  task automatic load_frame();
    for (int i = 0; i < W*H; i++) px_q.push_back(fr[i]);
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        win_t e;
        e.w = '0;
        for (int k = 0; k < 9; k++) e.w = {e.w[47:0], fr[(r-2+k/3)*W + (c-2+k%3)]};
        e.last = (r == H-1) && (c == W-1);
        exp_q.push_back(e);
      end
    end
  endtask

  // One clock: drive at negedge, observe handshakes, advance to next negedge
  task automatic cycle(input bit iv_en, input bit ordy);
    in_valid  = iv_en && (px_q.size() > 0);
    in_pixel  = (px_q.size() > 0) ? px_q[0] : '0;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      got_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_window: got %0h last=%0b expected none", dut_win(), out_last);
      end else begin
        win_t e;
        e = exp_q.pop_front();
        chk("window", {9'b0, out_last, dut_win()}, {9'b0, e.last, e.w});
      end
    end
    if (in_valid && in_ready) void'(px_q.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int maxc, input bit rnd);
    int n;
    int exp_n;
    n = 0;
    exp_n = exp_q.size();
    got_cnt = 0;
    while ((px_q.size() > 0 || exp_q.size() > 0) && n < maxc) begin
      if (rnd) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      else     cycle(1'b1, 1'b1);
      n++;
    end
    chk("drain_left", 64'(px_q.size() + exp_q.size()), 64'd0);
    chk("win_count", 64'(got_cnt), 64'(exp_n));
    px_q.delete();
    exp_q.delete();
    cycle(1'b0, 1'b1);
    chk("idle_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b1, 6'd0,  1'b0, 1'b0, 6'd0, 6'd0};
    vt[1]  = '{1'b1, 1'b1, 6'd1,  1'b0, 1'b0, 6'd0, 6'd0};
    vt[2]  = '{1'b1, 1'b1, 6'd2,  1'b0, 1'b0, 6'd0, 6'd0};
    vt[3]  = '{1'b1, 1'b1, 6'd3,  1'b0, 1'b0, 6'd0, 6'd0};
    vt[4]  = '{1'b1, 1'b1, 6'd4,  1'b0, 1'b0, 6'd0, 6'd0};
    vt[5]  = '{1'b1, 1'b1, 6'd5,  1'b0, 1'b0, 6'd0, 6'd0};
    vt[6]  = '{1'b1, 1'b1, 6'd6,  1'b0, 1'b0, 6'd0, 6'd0};
    vt[7]  = '{1'b1, 1'b1, 6'd7,  1'b0, 1'b0, 6'd0, 6'd0};
    vt[8]  = '{1'b1, 1'b1, 6'd8,  1'b0, 1'b0, 6'd0, 6'd0};
    vt[9]  = '{1'b1, 1'b1, 6'd9,  1'b0, 1'b0, 6'd0, 6'd0};
    vt[10] = '{1'b1, 1'b1, 6'd10, 1'b1, 1'b0, 6'd0, 6'd10};
    vt[11] = '{1'b1, 1'b1, 6'd11, 1'b1, 1'b0, 6'd1, 6'd11};
    vt[12] = '{1'b1, 1'b1, 6'd12, 1'b0, 1'b0, 6'd0, 6'd0};
    vt[13] = '{1'b1, 1'b1, 6'd13, 1'b0, 1'b0, 6'd0, 6'd0};
    vt[14] = '{1'b1, 1'b1, 6'd14, 1'b1, 1'b0, 6'd4, 6'd14};
    vt[15] = '{1'b1, 1'b1, 6'd15, 1'b1, 1'b1, 6'd5, 6'd15};
    vt[16] = '{1'b0, 1'b1, 6'd0,  1'b0, 1'b0, 6'd0, 6'd0};

    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last",  64'(out_last),  64'd0);
    chk("rst_ready", 64'(in_ready),  64'd1);
    chk("rst_win",   64'(dut_win()), 64'd0);

    // Table-driven full frame, pixel(r,c) = 4r+c
    for (int i = 0; i < 17; i++) begin
      in_valid  = vt[i].iv;
      in_pixel  = vt[i].px;
      out_ready = vt[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(vt[i].ov));
      chk($sformatf("tbl%0d_last", i),  64'(out_last),  64'(vt[i].lst));
      if (vt[i].ov) begin
        chk($sformatf("tbl%0d_w0", i), 64'(win_0), 64'(vt[i].w0));
        chk($sformatf("tbl%0d_w8", i), 64'(win_8), 64'(vt[i].w8));
      end
      @(negedge clk);
    end

    // Same frame against the reference model
    for (int i = 0; i < W*H; i++) fr[i] = DW'(i);
    load_frame();
    drain(100, 1'b0);

    // Backpressure: hold the first window for 5 cycles
    load_frame();
    got_cnt = 0;
    for (int n = 0; n < 30 && !out_valid; n++) cycle(1'b1, 1'b1);
    chk("bp_first_valid", 64'(out_valid), 64'd1);
    for (int n = 0; n < 5; n++) begin
      cycle(1'b1, 1'b0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_win", 64'(dut_win()),
          64'({6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9, 6'd10}));
    end
    drain(100, 1'b0);

    // Random input gaps and random out_ready
    load_frame();
    drain(400, 1'b1);

    // Back-to-back frames, second offset by 16
    load_frame();
    for (int i = 0; i < W*H; i++) fr[i] = DW'((i + 16) % 64);
    load_frame();
    drain(200, 1'b0);

    // Random pixel frames back-to-back with random gaps
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < W*H; i++) fr[i] = DW'($urandom);
      load_frame();
    end
    drain(1500, 1'b1);

    // Reset mid-frame after pixel 9, then a fresh frame
    for (int i = 0; i < 10; i++) px_q.push_back(DW'(i));
    drain(50, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_pixel = 6'd63; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_last",  64'(out_last),  64'd0);
    for (int i = 0; i < W*H; i++) fr[i] = DW'(i);
    load_frame();
    drain(100, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
